imem_arbiter: RTL and testbench

- Shares the single combinational IMEM read port between two requesters: the core instruction-fetch port (F_*, priority) and the debug/loader read port (D_*).
- Converts byte addresses to word addresses, checks alignment and range, drives IMEM RDEN/ADDR, and registers IMEM output into per-requester response registers.
- A starvation counter guarantees debug progress under continuous fetch traffic.
- Sits between the fetch stage/debug module and IMEM.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_resp_reg.sv | 47 ++++
 rtl/imem_arbiter.sv | 97 +++++++++
 tb/tb_imem_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the IMEM read-port arbiter.
package imem_pkg;

  localparam int unsigned IMEM_ADDR_DEPTH = 14;

  typedef enum logic [0:0] {
    ARB_FETCH = 1'b0,
    ARB_DEBUG = 1'b1
  } arb_state_e;

  // Returns the error flag for a byte address: 1 when the address is not
  // word aligned or has any bit set above the IMEM word range.
  function automatic logic imem_addr_ok(input logic [31:0] addr, input int unsigned depth);
    logic [31:0] hi_mask;
    hi_mask = ~((32'd1 << (depth + 2)) - 32'd1);
    return (addr[1:0] != 2'b00) || ((addr & hi_mask) != 32'd0);
  endfunction

endpackage

// File: rtl/imem_resp_reg.sv
// Per-requester response register: one-cycle valid pulse, error flag and
// read data captured at the grant edge. Data holds when no grant occurs.
module imem_resp_reg
  import imem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        capture_i,
  input  logic        err_i,
  input  logic [31:0] data_i,
  output logic        valid_o,
  output logic        err_o,
  output logic [31:0] data_o
);

  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] data_q, data_d;

  // Next-state: erroring grants return zero data; idle cycles keep old data.
  always_comb begin
    valid_d = capture_i;
    err_d   = capture_i & err_i;
    data_d  = data_q;
    if (capture_i) begin
      data_d = err_i ? 32'd0 : data_i;
    end
  end

  // Response state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign data_o  = data_q;

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of the single combinational IMEM read port.
// Fetch has priority; a streak counter forces a debug grant after
// MAX_STREAK consecutive fetch grants while debug is waiting.
//
// state     | meaning
// ARB_FETCH | fetch wins when requesting, otherwise debug
// ARB_DEBUG | debug wins; falls back to fetch if debug has dropped
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_DEPTH = IMEM_ADDR_DEPTH,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  f_req_i,
  input  logic [31:0]           f_addr_i,
  output logic                  f_gnt_o,
  output logic                  f_valid_o,
  output logic [31:0]           f_data_o,
  output logic                  f_err_o,
  input  logic                  d_req_i,
  input  logic [31:0]           d_addr_i,
  output logic                  d_gnt_o,
  output logic                  d_valid_o,
  output logic [31:0]           d_data_o,
  output logic                  d_err_o,
  output logic                  imem_rden_o,
  output logic [ADDR_DEPTH-1:0] imem_addr_o,
  input  logic [31:0]           imem_dout_i
);

  localparam logic [3:0] STREAK_LAST = 4'(MAX_STREAK - 1);

  arb_state_e state_q;
  logic [3:0] streak_q;

  logic        f_gnt, d_gnt, any_gnt;
  logic [31:0] sel_addr;
  logic        sel_err;

  // Grant decode and IMEM port drive; grants are combinational from REQ and state.
  always_comb begin
    f_gnt    = f_req_i && ((state_q == ARB_FETCH) || !d_req_i);
    d_gnt    = d_req_i && ((state_q == ARB_DEBUG) || !f_req_i);
    any_gnt  = f_gnt || d_gnt;
    sel_addr = d_gnt ? d_addr_i : f_addr_i;
    sel_err  = imem_addr_ok(sel_addr, ADDR_DEPTH);
    imem_rden_o = any_gnt && !sel_err;
    imem_addr_o = any_gnt ? sel_addr[ADDR_DEPTH+1:2] : '0;
  end

  // Arbitration FSM and starvation streak counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ARB_FETCH;
      streak_q <= 4'd0;
    end else if (!d_req_i || d_gnt) begin
      state_q  <= ARB_FETCH;
      streak_q <= 4'd0;
    end else if (f_gnt) begin
      // Debug is waiting while fetch wins: count it, hand over at the limit.
      if (streak_q == STREAK_LAST) begin
        state_q <= ARB_DEBUG;
      end
      if (streak_q != 4'hF) begin
        streak_q <= streak_q + 4'd1;
      end
    end
  end

  assign f_gnt_o = f_gnt;
  assign d_gnt_o = d_gnt;

  imem_resp_reg u_f_resp (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .capture_i (f_gnt),
    .err_i     (sel_err),
    .data_i    (imem_dout_i),
    .valid_o   (f_valid_o),
    .err_o     (f_err_o),
    .data_o    (f_data_o)
  );

  imem_resp_reg u_d_resp (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .capture_i (d_gnt),
    .err_i     (sel_err),
    .data_i    (imem_dout_i),
    .valid_o   (d_valid_o),
    .err_o     (d_err_o),
    .data_o    (d_data_o)
  );

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed stimulus, queue scoreboard, negedge monitor.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_req, d_req;
  logic [31:0] f_addr, d_addr;
  logic        f_gnt, d_gnt, f_valid, d_valid, f_err, d_err;
  logic [31:0] f_data, d_data;
  logic        imem_rden;
  logic [13:0] imem_addr;
  logic [31:0] imem_dout;

  logic [31:0] mem [16384];

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  resp_t fq[$];
  resp_t dq[$];
  resp_t fr, dr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_dout = mem[imem_addr];

  imem_arbiter #(.ADDR_DEPTH(14), .MAX_STREAK(4)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .f_req_i     (f_req),
    .f_addr_i    (f_addr),
    .f_gnt_o     (f_gnt),
    .f_valid_o   (f_valid),
    .f_data_o    (f_data),
    .f_err_o     (f_err),
    .d_req_i     (d_req),
    .d_addr_i    (d_addr),
    .d_gnt_o     (d_gnt),
    .d_valid_o   (d_valid),
    .d_data_o    (d_data),
    .d_err_o     (d_err),
    .imem_rden_o (imem_rden),
    .imem_addr_o (imem_addr),
    .imem_dout_i (imem_dout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected response", name);
  endtask

  // Monitor: pop and compare whenever a response is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (f_valid === 1'b1) begin
        if (fq.size() == 0) fail_now("f_unexpected_valid");
        else begin
          fr = fq.pop_front();
          check("f_err", 32'(f_err), 32'(fr.err));
          check("f_data", f_data, fr.data);
        end
      end
      if (d_valid === 1'b1) begin
        if (dq.size() == 0) fail_now("d_unexpected_valid");
        else begin
          dr = dq.pop_front();
          check("d_err", 32'(d_err), 32'(dr.err));
          check("d_data", d_data, dr.data);
        end
      end
    end
  end

  // Issue one request on either port and wait (bounded) for its grant.
  task automatic access(input bit dbg, input logic [31:0] addr, input logic exp_err,
                        input logic [31:0] exp_data, input logic [13:0] exp_word);
    bit done;
    done = 1'b0;
    if (dbg) begin d_req = 1'b1; d_addr = addr; end
    else     begin f_req = 1'b1; f_addr = addr; end
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if ((dbg ? d_gnt : f_gnt) === 1'b1) begin
        if (!exp_err) check("grant_imem_addr", 32'(imem_addr), 32'(exp_word));
        check("grant_imem_rden", 32'(imem_rden), 32'(!exp_err));
        if (dbg) dq.push_back(resp_t'({exp_err, exp_data}));
        else     fq.push_back(resp_t'({exp_err, exp_data}));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    f_req = 1'b0;
    d_req = 1'b0;
    if (!done) fail_now(dbg ? "d_gnt_timeout" : "f_gnt_timeout");
  endtask

  initial begin
    logic [31:0] b2b_exp [3];
    bit exp_d;
    b2b_exp[0] = 32'h1111_1111;
    b2b_exp[1] = 32'h2222_2222;
    b2b_exp[2] = 32'h3333_3333;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    mem[0] = 32'h1111_1111;
    mem[1] = 32'h2222_2222;
    mem[2] = 32'h3333_3333;
    mem[4] = 32'hDEAD_BEEF;
    mem[8] = 32'h8888_8888;
    mem[16383] = 32'hCAFE_F00D;

    f_req = 1'b0; d_req = 1'b0; f_addr = '0; d_addr = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_f_valid", 32'(f_valid), 0);
    check("rst_d_valid", 32'(d_valid), 0);
    check("rst_f_err", 32'(f_err), 0);
    check("rst_d_err", 32'(d_err), 0);
    check("rst_f_data", f_data, 0);
    check("rst_d_data", d_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle: no grants, no responses, IMEM port quiet.
    repeat (3) begin
      @(negedge clk);
      check("idle_rden", 32'(imem_rden), 0);
      check("idle_addr", 32'(imem_addr), 0);
      check("idle_f_valid", 32'(f_valid), 0);
      check("idle_d_valid", 32'(d_valid), 0);
      @(posedge clk); #1;
    end

    // Single fetch, then valid is a one-cycle pulse and data holds.
    access(1'b0, 32'h0000_0010, 1'b0, 32'hDEAD_BEEF, 14'd4);
    @(negedge clk);
    check("single_f_valid", 32'(f_valid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_f_valid_drop", 32'(f_valid), 0);
    check("single_f_data_hold", f_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Reset during a granted request discards the response.
    f_req = 1'b1; f_addr = 32'h0000_0020;
    @(negedge clk);
    check("rstmid_f_gnt", 32'(f_gnt), 1);
    #1 rst_n = 1'b0;
    f_req = 1'b0;
    @(posedge clk); #1;
    check("rstmid_f_valid", 32'(f_valid), 0);
    check("rstmid_f_data", f_data, 0);
    check("rstmid_f_err", 32'(f_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rstmid_no_f_valid", 32'(f_valid), 0);
      check("rstmid_no_d_valid", 32'(d_valid), 0);
    end
    @(posedge clk); #1;

    // Starvation bound: F,F,F,F,D repeating.
    f_req = 1'b1; f_addr = 32'h0000_0010;
    d_req = 1'b1; d_addr = 32'h0000_0020;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_d = (c == 4) || (c == 9);
      check($sformatf("starve_d_gnt_c%0d", c), 32'(d_gnt), 32'(exp_d));
      check($sformatf("starve_f_gnt_c%0d", c), 32'(f_gnt), 32'(!exp_d));
      if (exp_d) dq.push_back(resp_t'({1'b0, 32'h8888_8888}));
      else       fq.push_back(resp_t'({1'b0, 32'hDEAD_BEEF}));
      @(posedge clk); #1;
    end
    f_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;

    // Misaligned fetch and out-of-range debug: granted, no read, error response.
    access(1'b0, 32'h0000_0002, 1'b1, 32'd0, 14'd0);
    access(1'b1, 32'h0001_0000, 1'b1, 32'd0, 14'd0);
    @(posedge clk); #1;

    // Back-to-back fetches produce back-to-back responses in order.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin f_req = 1'b1; f_addr = 32'(i * 4); end
      else f_req = 1'b0;
      @(negedge clk);
      if (i < 3) begin
        check($sformatf("b2b_gnt_%0d", i), 32'(f_gnt), 1);
        fq.push_back(resp_t'({1'b0, b2b_exp[i]}));
      end
      if (i > 0) check($sformatf("b2b_valid_%0d", i), 32'(f_valid), 1);
      @(posedge clk); #1;
    end

    // Debug only, last IMEM word.
    access(1'b1, 32'h0000_FFFC, 1'b0, 32'hCAFE_F00D, 14'h3FFF);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("f_queue_drained", 32'(fq.size()), 0);
    check("d_queue_drained", 32'(dq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
